// File: rtl/eeprom_arbiter_pkg.sv
// Shared definitions for the two-port EEPROM arbiter: one-hot state encoding,
// port indices and the post-write wait derivation.
package eeprom_arbiter_pkg;

    typedef enum logic [5:0] {
        S_IDLE      = 6'b000001,
        S_ISSUE     = 6'b000010,
        S_WAIT_BUSY = 6'b000100,
        S_WAIT_DONE = 6'b001000,
        S_TWR       = 6'b010000,
        S_ACK       = 6'b100000
    } state_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    function automatic int unsigned twr_cycles(input int unsigned sys_freq,
                                               input int unsigned twr_ms);
        return sys_freq / 1000 * twr_ms;
    endfunction

endpackage

// File: rtl/eeprom_arbiter.sv
// Round-robin arbiter sharing one i2c EEPROM byte engine between two requesters,
// one byte at a time, holding off further accesses for tWR after every write.
module eeprom_arbiter
    import eeprom_arbiter_pkg::*;
#(
    parameter int unsigned SYS_FREQ = 12_090_000,
    parameter int unsigned TWR_MS   = 5,
    parameter int unsigned BUSY_TO  = 7
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       req0,
    input  logic       req1,
    input  logic       we0,
    input  logic       we1,
    input  logic [8:0] addr0,
    input  logic [8:0] addr1,
    input  logic [7:0] wdat0,
    input  logic [7:0] wdat1,
    output logic       ack0,
    output logic       ack1,
    output logic       err,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       i2c_wrreq,
    output logic       i2c_rdreq,
    output logic [8:0] i2c_waddr,
    output logic [8:0] i2c_raddr,
    output logic [7:0] i2c_wdata,
    input  logic [7:0] i2c_rdata,
    input  logic       i2c_rdy
);

    localparam int unsigned TWR_CYC  = twr_cycles(SYS_FREQ, TWR_MS);
    localparam int          TO_W     = $clog2(BUSY_TO + 1);
    localparam logic [19:0] TWR_LAST = 20'(TWR_CYC - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TO - 1);

    state_e          state_q, state_d;
    logic            gnt_q, gnt_d;
    logic            last_gnt_q, last_gnt_d;
    logic            we_q, we_d;
    logic            err_q, err_d;
    logic [8:0]      addr_q, addr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [7:0]      rdata_q, rdata_d;
    logic [19:0]     twr_q, twr_d;
    logic [TO_W-1:0] to_q, to_d;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= S_IDLE;
            gnt_q      <= PORT0;
            last_gnt_q <= PORT1;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            twr_q      <= '0;
            to_q       <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            we_q       <= we_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            twr_q      <= twr_d;
            to_q       <= to_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        we_d       = we_q;
        err_d      = err_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        twr_d      = twr_q;
        to_d       = to_q;
        unique case (state_q)
            S_IDLE: begin
                // An externally busy engine blocks granting even with requests pending.
                if ((req0 || req1) && i2c_rdy) begin
                    gnt_d   = (req0 && req1) ? ~last_gnt_q : req1;
                    we_d    = (gnt_d == PORT1) ? we1   : we0;
                    addr_d  = (gnt_d == PORT1) ? addr1 : addr0;
                    wdata_d = (gnt_d == PORT1) ? wdat1 : wdat0;
                    err_d   = 1'b0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                to_d    = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!i2c_rdy) begin
                    state_d = S_WAIT_DONE;
                end else if (to_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_ACK;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (i2c_rdy) begin
                    if (we_q) begin
                        twr_d   = '0;
                        state_d = S_TWR;
                    end else begin
                        rdata_d = i2c_rdata;
                        state_d = S_ACK;
                    end
                end
            end
            S_TWR: begin
                if (twr_q == TWR_LAST) state_d = S_ACK;
                else                   twr_d   = twr_q + 20'd1;
            end
            S_ACK: begin
                last_gnt_d = gnt_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign ack0      = (state_q == S_ACK) && (gnt_q == PORT0);
    assign ack1      = (state_q == S_ACK) && (gnt_q == PORT1);
    assign err       = (state_q == S_ACK) && err_q;
    assign rdata     = rdata_q;
    assign i2c_wrreq = (state_q == S_ISSUE) && we_q;
    assign i2c_rdreq = (state_q == S_ISSUE) && !we_q;
    assign i2c_waddr = addr_q;
    assign i2c_raddr = addr_q;
    assign i2c_wdata = wdata_q;

endmodule

// File: tb/tb_eeprom_arbiter.sv
// Bench for eeprom_arbiter: behavioural i2c engine with memory, plus a scoreboard of
// expected EEPROM contents and round-robin grant order derived from the arbitration rules.
module tb_eeprom_arbiter;

    localparam int unsigned SYS_FREQ = 100_000;
    localparam int unsigned TWR_MS   = 1;
    localparam int unsigned BUSY_TO  = 7;
    localparam int TWR_CYC  = 100;
    localparam int ENG_FALL = 2;
    localparam int ENG_LOW  = 400;
    localparam int LAT_RD   = 1 + ENG_FALL + ENG_LOW + 1;

    logic       clk = 1'b0;
    logic       nrst = 1'b1;
    logic       req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [8:0] addr0 = '0, addr1 = '0;
    logic [7:0] wdat0 = '0, wdat1 = '0;
    logic       ack0, ack1, err, busy, i2c_wrreq, i2c_rdreq;
    logic [7:0] rdata, i2c_wdata;
    logic [7:0] i2c_rdata;
    logic [8:0] i2c_waddr, i2c_raddr;
    logic       i2c_rdy;

    int checks = 0;
    int errors = 0;

    eeprom_arbiter #(.SYS_FREQ(SYS_FREQ), .TWR_MS(TWR_MS), .BUSY_TO(BUSY_TO)) dut (
        .clk(clk), .nrst(nrst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdat0(wdat0), .wdat1(wdat1),
        .ack0(ack0), .ack1(ack1), .err(err), .rdata(rdata), .busy(busy),
        .i2c_wrreq(i2c_wrreq), .i2c_rdreq(i2c_rdreq),
        .i2c_waddr(i2c_waddr), .i2c_raddr(i2c_raddr), .i2c_wdata(i2c_wdata),
        .i2c_rdata(i2c_rdata), .i2c_rdy(i2c_rdy)
    );

    always #5 clk = ~clk;

    // Power-on EEPROM content; 0x012 holds 0xA5
    logic [7:0] seed_b = 8'h00;
    function automatic logic [7:0] base(input logic [8:0] a);
        if (a == 9'h012) return 8'hA5;
        return 8'(a * 97) ^ seed_b;
    endfunction

    // Behavioural byte engine: rdy falls 2 cycles after a strobe, rises 400 cycles later
    logic [7:0] eep   [512];
    bit         eep_w [512];
    bit         eng_dead = 1'b0;
    logic       eng_active;
    int         eng_cnt;
    int         overlap = 0;
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            i2c_rdy    <= 1'b1;
            eng_active <= 1'b0;
            eng_cnt    <= 0;
            i2c_rdata  <= 8'h00;
        end else if (i2c_wrreq || i2c_rdreq) begin
            if (eng_active || !i2c_rdy || (i2c_wrreq && i2c_rdreq)) overlap <= overlap + 1;
            if (!eng_dead) begin
                eng_active <= 1'b1;
                eng_cnt    <= 0;
                if (i2c_wrreq) begin
                    eep[i2c_waddr]   <= i2c_wdata;
                    eep_w[i2c_waddr] <= 1'b1;
                end else begin
                    i2c_rdata <= eep_w[i2c_raddr] ? eep[i2c_raddr] : base(i2c_raddr);
                end
            end
        end else if (eng_active) begin
            eng_cnt <= eng_cnt + 1;
            if (eng_cnt == 0) i2c_rdy <= 1'b0;
            if (eng_cnt == ENG_LOW) begin
                i2c_rdy    <= 1'b1;
                eng_active <= 1'b0;
            end
        end
    end

    // Scoreboard memory: what each address should read back
    logic [7:0] ref_mem [512];
    bit         ref_w   [512];
    function automatic logic [7:0] ref_rd(input logic [8:0] a);
        return ref_w[a] ? ref_mem[a] : base(a);
    endfunction

    int cyc = 0, n_rd = 0, n_wr = 0, n_ack = 0, strobe_cyc = 0, rise_cyc = 0;
    logic [8:0] s_addr = '0;
    logic [7:0] s_wdata = '0;
    logic       rdy_d = 1'b1;
    always @(negedge clk) begin
        cyc++;
        if (i2c_rdreq) begin n_rd++; s_addr = i2c_raddr; strobe_cyc = cyc; end
        if (i2c_wrreq) begin n_wr++; s_addr = i2c_waddr; s_wdata = i2c_wdata; strobe_cyc = cyc; end
        if (ack0 || ack1) n_ack++;
        if (i2c_rdy && !rdy_d) rise_cyc = cyc;
        rdy_d = i2c_rdy;
    end

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic req_on(input int p, input logic w, input logic [8:0] a, input logic [7:0] d);
        if (p == 0) begin req0 = 1; we0 = w; addr0 = a; wdat0 = d; end
        else        begin req1 = 1; we1 = w; addr1 = a; wdat1 = d; end
    endtask

    task automatic req_off(input int p);
        if (p == 0) req0 = 0; else req1 = 0;
    endtask

    task automatic do_reset();
        req0 = 0; req1 = 0;
        tick();
        nrst = 0;
        repeat (3) tick();
        nrst = 1;
        tick();
    endtask

    task automatic wait_ack(input int budget, output int port, output logic e,
                            output logic [7:0] rd, output int at);
        port = -1; e = 1'bx; rd = 8'hxx; at = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (ack0 || ack1) begin
                port = ack1 ? 1 : 0; e = err; rd = rdata; at = cyc;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL wait_ack: no ack within %0d cycles, required one", budget);
    endtask

    task automatic test_reset();
        logic [39:0] outs;
        tick();
        outs = {ack0, ack1, err, rdata, busy, i2c_wrreq, i2c_rdreq, i2c_waddr, i2c_raddr, i2c_wdata};
        checks++;
        if (outs !== 40'h0) begin errors++; $display("FAIL reset_outputs: got %h required 0", outs); end
        nrst = 1;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b required 0", busy); end
    endtask

    task automatic test_read();
        int p, at, t0, rd0, wr0, a0;
        logic e; logic [7:0] rd;
        rd0 = n_rd; wr0 = n_wr;
        req_on(0, 0, 9'h012, 8'h00); t0 = cyc;
        wait_ack(LAT_RD + 20, p, e, rd, at);
        req_off(0);
        a0 = n_ack;
        checks++; if (p !== 0) begin errors++; $display("FAIL read_port: got %0d required 0", p); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL read_err: got %b required 0", e); end
        checks++; if (rd !== 8'hA5) begin errors++; $display("FAIL read_data: got %h required a5", rd); end
        checks++; if (n_rd - rd0 !== 1 || n_wr != wr0) begin
            errors++; $display("FAIL read_strobes: got rd=%0d wr=%0d required rd=1 wr=0", n_rd - rd0, n_wr - wr0); end
        checks++; if (s_addr !== 9'h012) begin errors++; $display("FAIL read_raddr: got %h required 012", s_addr); end
        checks++; if (at - t0 !== LAT_RD) begin errors++; $display("FAIL read_latency: got %0d required %0d", at - t0, LAT_RD); end
        repeat (5) tick();
        checks++; if (n_ack !== a0 || busy !== 1'b0) begin
            errors++; $display("FAIL read_single_ack: extra acks %0d busy %b required 0 0", n_ack - a0, busy); end
    endtask

    task automatic test_read_random();
        int p, at, port;
        logic e; logic [7:0] rd; logic [8:0] a;
        for (int k = 0; k < 4; k++) begin
            port = int'($urandom_range(0, 1));
            a = 9'($urandom_range(0, 511));
            req_on(port, 0, a, 8'h00);
            wait_ack(LAT_RD + 20, p, e, rd, at);
            req_off(port);
            checks++;
            if (p !== port || e !== 1'b0 || rd !== ref_rd(a)) begin
                errors++;
                $display("FAIL rand_read[%0d]: got port=%0d err=%b data=%h required port=%0d err=0 data=%h",
                         k, p, e, rd, port, ref_rd(a));
            end
            tick();
        end
    endtask

    task automatic test_write();
        int p, at, wr0;
        logic e; logic [7:0] rd;
        wr0 = n_wr;
        req_on(1, 1, 9'h1FF, 8'h3C);
        wait_ack(LAT_RD + TWR_CYC + 20, p, e, rd, at);
        req_off(1);
        ref_mem[9'h1FF] = 8'h3C; ref_w[9'h1FF] = 1'b1;
        checks++; if (p !== 1 || e !== 1'b0) begin errors++; $display("FAIL write_ack: got port=%0d err=%b required 1 0", p, e); end
        checks++; if (n_wr - wr0 !== 1) begin errors++; $display("FAIL write_strobes: got %0d required 1", n_wr - wr0); end
        checks++; if (s_addr !== 9'h1FF || s_wdata !== 8'h3C) begin
            errors++; $display("FAIL write_bus: got addr=%h data=%h required 1ff 3c", s_addr, s_wdata); end
        // TWR_CYC full wait cycles lie between the cycle rdy is seen high and the ack cycle
        checks++; if (at - rise_cyc !== TWR_CYC + 1) begin
            errors++; $display("FAIL write_twr: got %0d required %0d", at - rise_cyc, TWR_CYC + 1); end
        tick();
        req_on(0, 0, 9'h1FF, 8'h00);
        wait_ack(LAT_RD + 20, p, e, rd, at);
        req_off(0);
        checks++; if (p !== 0 || rd !== ref_rd(9'h1FF)) begin
            errors++; $display("FAIL write_readback: got port=%0d data=%h required 0 %h", p, rd, ref_rd(9'h1FF)); end
        tick();
    endtask

    task automatic test_back_to_back();
        int p, at, exp_port, last, rd0;
        logic e; logic [7:0] rd; logic [8:0] a [2];
        do_reset();
        a[0] = 9'($urandom_range(0, 255));
        a[1] = 9'($urandom_range(256, 511));
        rd0 = n_rd;
        last = 1;
        req_on(0, 0, a[0], 8'h00);
        req_on(1, 0, a[1], 8'h00);
        for (int k = 0; k < 4; k++) begin
            exp_port = 1 - last;
            wait_ack(LAT_RD + 20, p, e, rd, at);
            checks++;
            if (p !== exp_port || rd !== ref_rd(a[exp_port])) begin
                errors++;
                $display("FAIL rr_order[%0d]: got port=%0d data=%h required port=%0d data=%h",
                         k, p, rd, exp_port, ref_rd(a[exp_port]));
            end
            last = exp_port;
        end
        req_off(0); req_off(1);
        repeat (3) tick();
        checks++; if (n_rd - rd0 !== 4 || overlap !== 0) begin
            errors++; $display("FAIL rr_strobes: got strobes=%0d overlap=%0d required 4 0", n_rd - rd0, overlap); end
    endtask

    task automatic test_twr_block();
        int p, at, snap, a1;
        bit seen;
        logic e; logic [7:0] rd; logic [8:0] wa; logic [7:0] wd;
        wa = 9'($urandom_range(0, 511));
        wd = 8'($urandom_range(0, 255));
        req_on(1, 1, wa, wd);
        ref_mem[wa] = wd; ref_w[wa] = 1'b1;
        seen = 0;
        for (int i = 0; i < LAT_RD + 20 && !seen; i++) begin
            tick();
            if (!i2c_rdy) seen = 1;
        end
        seen = 0;
        for (int i = 0; i < LAT_RD + 20 && !seen; i++) begin
            tick();
            if (i2c_rdy) seen = 1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL twr_engine_done: rdy stayed low, required high"); end
        tick();
        req_on(0, 0, wa, 8'h00);
        snap = n_rd + n_wr;
        wait_ack(TWR_CYC + 20, p, e, rd, at);
        req_off(1);
        a1 = at;
        checks++; if (p !== 1 || n_rd + n_wr !== snap) begin
            errors++; $display("FAIL twr_hold: got port=%0d strobes_in_twr=%0d required 1 0", p, n_rd + n_wr - snap); end
        wait_ack(LAT_RD + 20, p, e, rd, at);
        req_off(0);
        checks++; if (p !== 0 || rd !== wd || strobe_cyc <= a1) begin
            errors++; $display("FAIL twr_then_p0: got port=%0d data=%h strobe_after_ack=%0d required 0 %h >0",
                               p, rd, wd, strobe_cyc - a1); end
        tick();
    endtask

    task automatic test_timeout();
        int p, at, t0, rd0;
        logic e; logic [7:0] rd;
        eng_dead = 1'b1;
        rd0 = n_rd;
        req_on(0, 0, 9'($urandom_range(0, 511)), 8'h00); t0 = cyc;
        wait_ack(40, p, e, rd, at);
        req_off(0);
        checks++; if (p !== 0 || e !== 1'b1) begin errors++; $display("FAIL timeout_ack: got port=%0d err=%b required 0 1", p, e); end
        checks++; if (at - t0 !== 2 + int'(BUSY_TO) || n_rd - rd0 !== 1) begin
            errors++; $display("FAIL timeout_timing: got lat=%0d strobes=%0d required %0d 1", at - t0, n_rd - rd0, 2 + BUSY_TO); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_idle: got busy=%b required 0", busy); end
        eng_dead = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int p, at, a0;
        bit seen;
        logic e; logic [7:0] rd; logic [8:0] a;
        logic [39:0] outs;
        req_on(0, 0, 9'($urandom_range(0, 511)), 8'h00);
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (!i2c_rdy) seen = 1;
        end
        repeat (50) tick();
        checks++; if (!seen || busy !== 1'b1) begin errors++; $display("FAIL midreset_setup: got busy=%b required 1", busy); end
        a0 = n_ack;
        nrst = 0;
        #1;
        outs = {ack0, ack1, err, rdata, busy, i2c_wrreq, i2c_rdreq, i2c_waddr, i2c_raddr, i2c_wdata};
        checks++; if (outs !== 40'h0) begin errors++; $display("FAIL midreset_outputs: got %h required 0", outs); end
        req_off(0);
        repeat (2) tick();
        nrst = 1;
        repeat (450) tick();
        checks++; if (n_ack !== a0 || busy !== 1'b0) begin
            errors++; $display("FAIL midreset_no_ack: got acks=%0d busy=%b required 0 0", n_ack - a0, busy); end
        a = 9'($urandom_range(0, 511));
        req_on(0, 0, a, 8'h00);
        wait_ack(LAT_RD + 20, p, e, rd, at);
        req_off(0);
        checks++; if (p !== 0 || e !== 1'b0 || rd !== ref_rd(a)) begin
            errors++; $display("FAIL midreset_fresh: got port=%0d err=%b data=%h required 0 0 %h", p, e, rd, ref_rd(a)); end
        tick();
    endtask

    initial begin
        seed_b = 8'($urandom);
        #2 nrst = 0;
        test_reset();
        test_read();
        test_read_random();
        test_write();
        test_back_to_back();
        test_twr_block();
        test_timeout();
        test_reset_mid();
        checks++;
        if (overlap !== 0) begin errors++; $display("FAIL no_overlap: got %0d overlapping strobes required 0", overlap); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
